// File: rtl/mem_arbiter_fill_pkg.sv
// Shared types and constants for the memory arbiter / block refill sequencer.
package mem_arbiter_fill_pkg;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT
  } state_t;

  typedef enum logic {
    OWN_I,
    OWN_D
  } owner_t;

  localparam int BLOCK_WORDS = 8;
  // Memory read latency; the RTL counts returned valids and never uses this.
  localparam int MEM_LAT = 4;

endpackage

// File: rtl/mem_arbiter_fill.sv
// Arbitrates the single memory port between I/D miss refills and D-cache write-through,
// and sequences the pipelined 8-word block refill for the cache that owns the port.
module mem_arbiter_fill
  import mem_arbiter_fill_pkg::*;
#(
  parameter int ADDR_W    = 16,
  parameter int DATA_W    = 16,
  parameter int WORD_BITS = 3
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 i_miss_req,
  input  logic [ADDR_W-1:0]    i_miss_addr,
  input  logic                 d_miss_req,
  input  logic [ADDR_W-1:0]    d_miss_addr,
  input  logic                 d_wr_req,
  input  logic [ADDR_W-1:0]    d_wr_addr,
  input  logic [DATA_W-1:0]    d_wr_data,
  output logic                 d_wr_ack,
  output logic                 mem_en,
  output logic                 mem_wr,
  output logic [ADDR_W-1:0]    mem_addr,
  output logic [DATA_W-1:0]    mem_wdata,
  input  logic                 mem_rvalid,
  input  logic [DATA_W-1:0]    mem_rdata,
  output logic                 i_fill_we,
  output logic                 d_fill_we,
  output logic [WORD_BITS-1:0] fill_word,
  output logic [DATA_W-1:0]    fill_data,
  output logic                 i_fill_done,
  output logic                 d_fill_done,
  output logic                 busy
);

  localparam int BASE_LSB = WORD_BITS + 1;

  state_t                     state;
  state_t                     stateNext;
  owner_t                     owner;
  logic [ADDR_W-1:BASE_LSB]   blkBase;
  logic [WORD_BITS-1:0]       issueCnt;
  logic [WORD_BITS-1:0]       retCnt;
  logic                       ready;
  logic                       grantI;
  logic                       grantD;
  logic                       fillActive;

  // Word/byte offset bits of the miss addresses are irrelevant: refills are block aligned.
  logic unusedAddrBits;
  assign unusedAddrBits = ^{i_miss_addr[BASE_LSB-1:0], d_miss_addr[BASE_LSB-1:0]};

  assign busy       = (state != IDLE);
  assign fillActive = (state != IDLE) && mem_rvalid;

  always_comb begin
    stateNext   = state;
    grantI      = 1'b0;
    grantD      = 1'b0;
    d_wr_ack    = 1'b0;
    mem_en      = 1'b0;
    mem_wr      = 1'b0;
    mem_addr    = '0;
    mem_wdata   = '0;
    i_fill_we   = 1'b0;
    d_fill_we   = 1'b0;
    fill_word   = '0;
    fill_data   = '0;
    i_fill_done = 1'b0;
    d_fill_done = 1'b0;

    case (state)
      IDLE: begin
        // ready holds off all grants while reset is (or was just) asserted.
        if (ready && d_wr_req) begin
          mem_en    = 1'b1;
          mem_wr    = 1'b1;
          mem_addr  = d_wr_addr;
          mem_wdata = d_wr_data;
          d_wr_ack  = 1'b1;
        end else if (ready && d_miss_req) begin
          grantD    = 1'b1;
          stateNext = ISSUE;
        end else if (ready && i_miss_req) begin
          grantI    = 1'b1;
          stateNext = ISSUE;
        end
      end
      ISSUE: begin
        mem_en   = 1'b1;
        mem_addr = {blkBase, issueCnt, 1'b0};
        if (issueCnt == '1) stateNext = WAIT;
      end
      default: ;
    endcase

    if (fillActive) begin
      fill_word = retCnt;
      fill_data = mem_rdata;
      if (owner == OWN_D) d_fill_we = 1'b1;
      else                i_fill_we = 1'b1;
      if (retCnt == '1) begin
        if (owner == OWN_D) d_fill_done = 1'b1;
        else                i_fill_done = 1'b1;
        stateNext = IDLE;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      owner    <= OWN_I;
      blkBase  <= '0;
      issueCnt <= '0;
      retCnt   <= '0;
      ready    <= 1'b0;
    end else begin
      ready <= 1'b1;
      state <= stateNext;
      if (grantI || grantD) begin
        owner    <= grantD ? OWN_D : OWN_I;
        blkBase  <= grantD ? d_miss_addr[ADDR_W-1:BASE_LSB] : i_miss_addr[ADDR_W-1:BASE_LSB];
        issueCnt <= '0;
        retCnt   <= '0;
      end else begin
        if (state == ISSUE) issueCnt <= issueCnt + 1'b1;
        if (fillActive)     retCnt   <= retCnt + 1'b1;
      end
    end
  end

endmodule
